// File: rtl/addr_seq_if.sv
// ----------------------------------------------------------------------------
// addr_seq_if
//   Bundles the control and status signals of the address sequencer so that
//   a buffer controller can hook up to one port.
//
//   Parameters
//     CNT_W   address width
//     STEP_W  width of the step magnitude
//
//   Signals (seen from the sequencer, i.e. the slave side)
//     start         in   start request, honoured in IDLE or DONE
//     enable        in   count qualifier
//     write_enable  in   count qualifier; both must be high to advance
//     dir           in   0 = count up, 1 = count down
//     step          in   increment magnitude, 0 = hold
//     load          in   parallel load strobe
//     load_val      in   value to load (clamped to DEPTH-1)
//     cnt           out  current buffer address
//     tc            out  one-cycle terminal-count pulse
//     done          out  sequencer is in DONE
//     busy          out  sequencer is in RUN
//     ovf           out  sticky flag: an out-of-range load was clamped
//
//   Modports
//     master  controller side (drives requests, observes status)
//     slave   sequencer side
// ----------------------------------------------------------------------------
interface addr_seq_if #(
  parameter int unsigned CNT_W  = 9,
  parameter int unsigned STEP_W = 4
) ();

  logic              start;
  logic              enable;
  logic              write_enable;
  logic              dir;
  logic [STEP_W-1:0] step;
  logic              load;
  logic [CNT_W-1:0]  load_val;

  logic [CNT_W-1:0]  cnt;
  logic              tc;
  logic              done;
  logic              busy;
  logic              ovf;

  modport master (
    output start, enable, write_enable, dir, step, load, load_val,
    input  cnt, tc, done, busy, ovf
  );

  modport slave (
    input  start, enable, write_enable, dir, step, load, load_val,
    output cnt, tc, done, busy, ovf
  );

endinterface

// File: rtl/addr_seq_counter.sv
// ----------------------------------------------------------------------------
// addr_seq_counter
//   Address sequencer for the multiplier / Newton buffers. Walks the address
//   range 0..DEPTH-1 up or down by a programmable step, either wrapping
//   around the range (WRAP=1) or parking on the last address and reporting
//   DONE (WRAP=0). A parallel load can reposition the address at any time.
//
//   Parameters
//     CNT_W   address width, DEPTH <= 2**CNT_W
//     DEPTH   number of valid addresses, DEPTH >= 2
//     STEP_W  width of the step input
//     WRAP    1 = wrap modulo DEPTH, 0 = stop at the end and go DONE
//
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous reset, active low, dominates every other input
//     bus    addr_seq_if slave modport (controls in, status out)
//
//   All outputs come straight from flops; a qualifying edge is visible on
//   cnt / tc / done / busy in the following cycle.
// ----------------------------------------------------------------------------
module addr_seq_counter #(
  parameter int unsigned CNT_W  = 9,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned STEP_W = 4,
  parameter bit          WRAP   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  addr_seq_if.slave  bus
);

  // Working width: one bit wider than the larger operand, so sums and
  // differences of an address and a step never overflow silently.
  localparam int unsigned AW = ((CNT_W > STEP_W) ? CNT_W : STEP_W) + 1;

  localparam logic [AW-1:0]    DEPTH_X = AW'(DEPTH);
  localparam logic [AW-1:0]    LAST_X  = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt_q;
  logic             tc_q;
  logic             done_q;
  logic             busy_q;
  logic             ovf_q;

  // --------------------------------------------------------------------------
  // Next-address arithmetic
  // --------------------------------------------------------------------------
  logic [AW-1:0]    cnt_x;
  logic [AW-1:0]    step_x;
  logic [AW-1:0]    step_m;     // step reduced modulo DEPTH
  logic [AW-1:0]    up_sum;
  logic [AW-1:0]    up_wrap;
  logic [AW-1:0]    dn_wrap;
  logic             advance;
  logic             terminal;
  logic             load_over;
  logic [CNT_W-1:0] normal_val;
  logic [CNT_W-1:0] wrap_val;
  logic [CNT_W-1:0] stop_val;
  logic [CNT_W-1:0] load_cnt;

  // NOTE: every signal written here gets a value on every path (defaults
  // first or full if/else), otherwise synthesis infers latches.
  always_comb begin
    cnt_x  = AW'(cnt_q);
    step_x = AW'(bus.step);

    // A step can exceed the whole range when DEPTH < 2**STEP_W; reducing it
    // first keeps the wrapped result a single conditional subtract.
    step_m = step_x % DEPTH_X;

    up_sum  = cnt_x + step_x;
    up_wrap = cnt_x + step_m;
    if (up_wrap >= DEPTH_X) begin
      up_wrap = up_wrap - DEPTH_X;
    end

    // cnt + DEPTH - step_m is always positive because step_m < DEPTH.
    dn_wrap = cnt_x + DEPTH_X - step_m;
    if (dn_wrap >= DEPTH_X) begin
      dn_wrap = dn_wrap - DEPTH_X;
    end

    if (bus.dir) begin
      terminal   = (cnt_x < step_x);
      normal_val = CNT_W'(cnt_x - step_x);
      wrap_val   = CNT_W'(dn_wrap);
      stop_val   = '0;
    end else begin
      terminal   = (up_sum > LAST_X);
      normal_val = CNT_W'(up_sum);
      wrap_val   = CNT_W'(up_wrap);
      stop_val   = LAST;
    end

    // A load in the same cycle suppresses the advance entirely.
    advance = (state == S_RUN) && bus.enable && bus.write_enable &&
              (bus.step != '0) && !bus.load;

    load_over = (AW'(bus.load_val) >= DEPTH_X);
    load_cnt  = load_over ? LAST : bus.load_val;
  end

  // --------------------------------------------------------------------------
  // Control FSM and registered outputs
  // --------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous: it is only seen on a clock edge, so it
    // needs no separate sensitivity entry.
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      tc_q <= 1'b0;

      // start is only honoured from IDLE or DONE; entering RUN leaves the
      // address where it is.
      if (bus.start && (state != S_RUN)) begin
        state  <= S_RUN;
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end

      if (bus.load) begin
        cnt_q <= load_cnt;
        if (load_over) begin
          ovf_q <= 1'b1;
        end
      end else if (advance) begin
        if (!terminal) begin
          cnt_q <= normal_val;
        end else begin
          tc_q <= 1'b1;
          if (WRAP) begin
            cnt_q <= wrap_val;
          end else begin
            // Park on the end of the range that was crossed.
            cnt_q  <= stop_val;
            state  <= S_DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.tc   = tc_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_addr_seq_counter.sv
// ----------------------------------------------------------------------------
// tb_addr_seq_counter
//   Three sequencers driven by the same controls:
//     dut 0: DEPTH=512, WRAP=1
//     dut 1: DEPTH=10,  WRAP=0
//     dut 2: DEPTH=10,  WRAP=1
//   Each applied cycle pushes the expected outputs of all three into a
//   queue, computed by a plain integer reference model; a monitor pops and
//   compares one frame after every rising edge. A few hand-computed
//   constants from the directed scenarios are checked as well.
// ----------------------------------------------------------------------------
module tb_addr_seq_counter;

  localparam int CNT_W  = 10;
  localparam int STEP_W = 4;
  localparam int N      = 3;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             tc;
    logic             done;
    logic             busy;
    logic             ovf;
  } obs_t;

  typedef obs_t [N-1:0] frame_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic              start        = 1'b0;
  logic              enable       = 1'b0;
  logic              write_enable = 1'b0;
  logic              dir          = 1'b0;
  logic [STEP_W-1:0] step         = '0;
  logic              load         = 1'b0;
  logic [CNT_W-1:0]  load_val     = '0;

  int vectors = 0;
  int miscompares = 0;

  frame_t exp_q[$];

  // Reference model state
  int depth_c [N] = '{512, 10, 10};
  bit wrap_c  [N] = '{1'b1, 1'b0, 1'b1};
  int m_cnt   [N];
  bit m_run   [N];
  bit m_fin   [N];
  bit m_tc    [N];
  bit m_ovf   [N];

  always #5 clk = ~clk;

  addr_seq_if #(.CNT_W(CNT_W), .STEP_W(STEP_W)) if_a ();
  addr_seq_if #(.CNT_W(CNT_W), .STEP_W(STEP_W)) if_b ();
  addr_seq_if #(.CNT_W(CNT_W), .STEP_W(STEP_W)) if_c ();

  assign if_a.start = start;  assign if_b.start = start;  assign if_c.start = start;
  assign if_a.enable = enable;  assign if_b.enable = enable;  assign if_c.enable = enable;
  assign if_a.write_enable = write_enable;  assign if_b.write_enable = write_enable;
  assign if_c.write_enable = write_enable;
  assign if_a.dir = dir;  assign if_b.dir = dir;  assign if_c.dir = dir;
  assign if_a.step = step;  assign if_b.step = step;  assign if_c.step = step;
  assign if_a.load = load;  assign if_b.load = load;  assign if_c.load = load;
  assign if_a.load_val = load_val;  assign if_b.load_val = load_val;
  assign if_c.load_val = load_val;

  addr_seq_counter #(.CNT_W(CNT_W), .DEPTH(512), .STEP_W(STEP_W), .WRAP(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  addr_seq_counter #(.CNT_W(CNT_W), .DEPTH(10), .STEP_W(STEP_W), .WRAP(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));
  addr_seq_counter #(.CNT_W(CNT_W), .DEPTH(10), .STEP_W(STEP_W), .WRAP(1'b1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c));

  // --------------------------------------------------------------------------
  // Reference model: plain integer arithmetic on the address range
  // --------------------------------------------------------------------------
  function automatic void model_step(input int d, input bit r, input bit st,
                                     input bit en, input bit we, input bit dr,
                                     input int sp, input bit ld, input int lv);
    bit was_run;
    int t;
    int dep;
    dep = depth_c[d];
    if (!r) begin
      m_cnt[d] = 0; m_run[d] = 0; m_fin[d] = 0; m_tc[d] = 0; m_ovf[d] = 0;
      return;
    end
    was_run  = m_run[d];
    m_tc[d]  = 0;
    if (ld) begin
      if (lv >= dep) begin
        m_cnt[d] = dep - 1;
        m_ovf[d] = 1;
      end else begin
        m_cnt[d] = lv;
      end
    end else if (was_run && en && we && sp != 0) begin
      t = dr ? m_cnt[d] - sp : m_cnt[d] + sp;
      if (t < 0 || t >= dep) begin
        m_tc[d] = 1;
        if (wrap_c[d]) begin
          m_cnt[d] = ((t % dep) + dep) % dep;
        end else begin
          m_cnt[d] = (t < 0) ? 0 : dep - 1;
          m_run[d] = 0;
          m_fin[d] = 1;
        end
      end else begin
        m_cnt[d] = t;
      end
    end
    if (!was_run && st) begin
      m_run[d] = 1;
      m_fin[d] = 0;
    end
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic cycle(input bit r, input bit st, input bit en, input bit we,
                       input bit dr, input int sp, input bit ld, input int lv);
    frame_t f;
    @(negedge clk);
    rst_n        = r;
    start        = st;
    enable       = en;
    write_enable = we;
    dir          = dr;
    step         = STEP_W'(sp);
    load         = ld;
    load_val     = CNT_W'(lv);
    for (int d = 0; d < N; d++) begin
      model_step(d, r, st, en, we, dr, sp, ld, lv);
      f[d].cnt  = CNT_W'(m_cnt[d]);
      f[d].tc   = m_tc[d];
      f[d].done = m_fin[d];
      f[d].busy = m_run[d];
      f[d].ovf  = m_ovf[d];
    end
    exp_q.push_back(f);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_start();
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_load(input int v);
    cycle(1, 0, 0, 0, 0, 0, 1, v);
  endtask

  task automatic do_adv(input bit dr, input int sp);
    cycle(1, 0, 1, 1, dr, sp, 0, 0);
  endtask

  // Wait until the edge following the last applied cycle has taken effect.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  function automatic obs_t get_act(input int d);
    obs_t o;
    case (d)
      0: begin o.cnt = if_a.cnt; o.tc = if_a.tc; o.done = if_a.done;
               o.busy = if_a.busy; o.ovf = if_a.ovf; end
      1: begin o.cnt = if_b.cnt; o.tc = if_b.tc; o.done = if_b.done;
               o.busy = if_b.busy; o.ovf = if_b.ovf; end
      default: begin o.cnt = if_c.cnt; o.tc = if_c.tc; o.done = if_c.done;
               o.busy = if_c.busy; o.ovf = if_c.ovf; end
    endcase
    return o;
  endfunction

  initial begin
    frame_t e;
    obs_t   a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int d = 0; d < N; d++) begin
          a = get_act(d);
          vectors++;
          if (a !== e[d]) begin
            miscompares++;
            $display("FAIL dut%0d t=%0t: got cnt=%0d tc=%b done=%b busy=%b ovf=%b, want cnt=%0d tc=%b done=%b busy=%b ovf=%b",
                     d, $time, a.cnt, a.tc, a.done, a.busy, a.ovf,
                     e[d].cnt, e[d].tc, e[d].done, e[d].busy, e[d].ovf);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed scenarios followed by random traffic
  // --------------------------------------------------------------------------
  initial begin
    int tc_seen;
    int t4_cnt [4] = '{8, 4, 0, 6};
    int t4_tc  [4] = '{1, 0, 0, 1};
    bit r, st, en, we, dr, ld;
    int sp, lv;

    // T1: reset in the middle of RUN with cnt=37
    do_reset(2);
    do_load(37);
    do_start();
    cycle(1, 0, 1, 0, 0, 3, 0, 0);
    settle();
    check("t1_pre_cnt", int'(if_a.cnt), 37);
    check("t1_pre_busy", int'(if_a.busy), 1);
    do_reset(2);
    settle();
    check("t1_cnt", int'(if_a.cnt), 0);
    check("t1_busy", int'(if_a.busy), 0);
    check("t1_done", int'(if_a.done), 0);
    check("t1_tc", int'(if_a.tc), 0);
    check("t1_ovf", int'(if_a.ovf), 0);

    // T2: full up-wrap on DEPTH=512, exactly one tc on 511 -> 0
    do_start();
    tc_seen = 0;
    for (int i = 0; i < 512; i++) begin
      do_adv(0, 1);
      settle();
      if (if_a.tc) tc_seen++;
    end
    check("t2_tc_count", tc_seen, 1);
    check("t2_end_cnt", int'(if_a.cnt), 0);

    // T3: stop mode on DEPTH=10, step 3
    do_reset(1);
    do_start();
    for (int i = 1; i <= 3; i++) begin
      do_adv(0, 3);
      settle();
      check("t3_cnt", int'(if_b.cnt), 3 * i);
      check("t3_tc", int'(if_b.tc), 0);
    end
    do_adv(0, 3);
    settle();
    check("t3_end_cnt", int'(if_b.cnt), 9);
    check("t3_end_tc", int'(if_b.tc), 1);
    check("t3_end_done", int'(if_b.done), 1);
    check("t3_end_busy", int'(if_b.busy), 0);
    do_adv(0, 3);
    settle();
    check("t3_hold_cnt", int'(if_b.cnt), 9);
    check("t3_hold_tc", int'(if_b.tc), 0);
    do_start();
    settle();
    check("t3_restart_busy", int'(if_b.busy), 1);
    check("t3_restart_done", int'(if_b.done), 0);
    check("t3_restart_cnt", int'(if_b.cnt), 9);

    // T4: down-wrap on DEPTH=10, step 4 from 2
    do_reset(1);
    do_start();
    do_load(2);
    for (int i = 0; i < 4; i++) begin
      do_adv(1, 4);
      settle();
      check("t4_cnt", int'(if_c.cnt), t4_cnt[i]);
      check("t4_tc", int'(if_c.tc), t4_tc[i]);
    end
    // dut 0 followed 2 -> 510 -> 506 -> 502 -> 498 in the same steps

    // T5: write_enable gating, then load of an out-of-range value during an advance
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0, 5, 0, 0);
    settle();
    check("t5_gate_cnt", int'(if_a.cnt), 498);
    cycle(1, 0, 1, 1, 0, 5, 1, 600);
    settle();
    check("t5_load_cnt", int'(if_a.cnt), 511);
    check("t5_load_ovf", int'(if_a.ovf), 1);
    check("t5_load_tc", int'(if_a.tc), 0);

    // T6: IDLE ignores the qualifiers; start in RUN is ignored
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), int'($urandom_range(1, 15)), 0, 0);
    end
    settle();
    check("t6_idle_cnt", int'(if_a.cnt), 0);
    check("t6_idle_busy", int'(if_a.busy), 0);
    do_start();
    do_start();
    settle();
    check("t6_run_busy", int'(if_a.busy), 1);
    check("t6_run_done", int'(if_a.done), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) != 0);
      ld = ($urandom_range(0, 15) == 0);
      st = !ld && ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 3) != 0);
      dr = bit'($urandom_range(0, 1));
      sp = int'($urandom_range(0, 15));
      lv = $urandom_range(0, 1) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 1023));
      cycle(r, st, en, we, dr, sp, ld, lv);
    end

    // Every pushed frame must have been consumed by the monitor.
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d frames left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
